// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round sequencer.
package aes_pkg;

  typedef enum logic [1:0] {
    AES128   = 2'd0,
    AES192   = 2'd1,
    AES256   = 2'd2,
    AES_RSVD = 2'd3
  } keylen_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_INIT,
    ST_KEY_WAIT,
    ST_ROUND,
    ST_DONE
  } ctrl_state_e;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  // Reserved key length maps to NR_128 so callers never see an undefined count.
  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    case (kl)
      AES192:  nr_of = NR_192;
      AES256:  nr_of = NR_256;
      default: nr_of = NR_128;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_counter.sv
// Round-key index counter: loads 0 (enc) or Nr (dec), steps on each strobe.
module aes_round_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       en,
  input  logic       dec,
  input  logic [3:0] nr,
  output logic [3:0] cnt,
  output logic       first,
  output logic       last
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= dec ? nr : 4'd0;
    end else if (en) begin
      cnt <= dec ? cnt - 4'd1 : cnt + 4'd1;
    end
  end

  assign first = dec ? (cnt == nr) : (cnt == 4'd0);
  assign last  = dec ? (cnt == 4'd0) : (cnt == nr);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequences key expansion and Nr+1 round strobes per block, caching key validity.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_WAIT_MAX = 1023,
  parameter int CW           = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       dec,
  input  logic [1:0] keylen,
  input  logic       key_change,
  input  logic       abort,
  input  logic       key_ready,
  input  logic       dp_ready,
  output logic       key_init,
  output logic       round_en,
  output logic [3:0] round_idx,
  output logic       round_first,
  output logic       round_last,
  output logic       busy,
  output logic       done,
  output logic       key_err
);

  localparam logic [CW-1:0] TMO_LAST = CW'(KEY_WAIT_MAX > 0 ? KEY_WAIT_MAX - 1 : 0);

  ctrl_state_e     state_q, state_d;
  logic            dec_q;
  logic [1:0]      kl_q;
  logic            cache_valid_q;
  logic [1:0]      cache_kl_q;
  logic [CW-1:0]   tmo_q;
  logic            key_err_q, key_err_d;
  logic            cnt_load, cache_set, cache_clr;
  logic            in_idle, in_round, timeout;
  logic            dec_cur, cnt_first, cnt_last;
  logic [3:0]      nr_cur, cnt;

  assign in_idle  = (state_q == ST_IDLE);
  assign in_round = (state_q == ST_ROUND);
  assign timeout  = (KEY_WAIT_MAX > 0) && (tmo_q == TMO_LAST);

  // A cache hit loads the counter in the same edge that captures dec/keylen,
  // so the load value must come straight from the inputs while idle.
  assign dec_cur = in_idle ? dec : dec_q;
  assign nr_cur  = nr_of(in_idle ? keylen : kl_q);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    key_err_d = 1'b0;
    cnt_load  = 1'b0;
    cache_set = 1'b0;
    cache_clr = key_change;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (keylen == AES_RSVD) begin
            key_err_d = 1'b1;
          end else if (cache_valid_q && (cache_kl_q == keylen) && !key_change) begin
            state_d  = ST_ROUND;
            cnt_load = 1'b1;
          end else begin
            state_d = ST_KEY_INIT;
          end
        end
      end
      ST_KEY_INIT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          cache_clr = 1'b1;
        end else begin
          state_d = ST_KEY_WAIT;
        end
      end
      ST_KEY_WAIT: begin
        if (abort) begin
          state_d   = ST_IDLE;
          cache_clr = 1'b1;
        end else if (key_ready) begin
          state_d   = ST_ROUND;
          cnt_load  = 1'b1;
          cache_set = 1'b1;
        end else if (timeout) begin
          state_d   = ST_IDLE;
          key_err_d = 1'b1;
          cache_clr = 1'b1;
        end
      end
      ST_ROUND: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (round_en && cnt_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      key_err_q <= 1'b0;
      dec_q     <= 1'b0;
      kl_q      <= 2'd0;
    end else begin
      state_q   <= state_d;
      key_err_q <= key_err_d;
      if (in_idle && start) begin
        dec_q <= dec;
        kl_q  <= keylen;
      end
    end
  end

  // A key change landing on the same edge as key_ready wins: the fresh
  // expansion describes the old key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid_q <= 1'b0;
      cache_kl_q    <= 2'd0;
    end else if (cache_clr) begin
      cache_valid_q <= 1'b0;
    end else if (cache_set) begin
      cache_valid_q <= 1'b1;
      cache_kl_q    <= kl_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else if (state_q == ST_KEY_INIT) begin
      tmo_q <= '0;
    end else if (state_q == ST_KEY_WAIT) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  aes_round_counter u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .en    (round_en),
    .dec   (dec_cur),
    .nr    (nr_cur),
    .cnt   (cnt),
    .first (cnt_first),
    .last  (cnt_last)
  );

  assign key_init    = (state_q == ST_KEY_INIT);
  assign busy        = !in_idle;
  assign done        = (state_q == ST_DONE);
  assign round_en    = in_round && dp_ready && !abort;
  assign round_idx   = cnt;
  assign round_first = in_round && cnt_first;
  assign round_last  = in_round && cnt_last;
  assign key_err     = key_err_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench: operation-level scoreboard for aes_round_ctrl.
module tb_aes_round_ctrl;

  localparam int KWM = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, dec = 1'b0, key_change = 1'b0, abort = 1'b0;
  logic       key_ready = 1'b0, dp_ready = 1'b1;
  logic [1:0] keylen = 2'd0;
  logic       key_init, round_en, round_first, round_last, busy, done, key_err;
  logic [3:0] round_idx;

  aes_round_ctrl #(.KEY_WAIT_MAX(KWM), .CW(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dec(dec), .keylen(keylen),
    .key_change(key_change), .abort(abort), .key_ready(key_ready),
    .dp_ready(dp_ready), .key_init(key_init), .round_en(round_en),
    .round_idx(round_idx), .round_first(round_first), .round_last(round_last),
    .busy(busy), .done(done), .key_err(key_err)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; bit first; bit last; } strobe_t;

  int      n_checks = 0, n_errors = 0;
  int      cyc = 0, dp_mode = 0, key_lat = 5;
  int      n_init, n_done, n_err, init_cyc, done_cyc, err_cyc;
  strobe_t strobes[$];
  bit      cv = 0;   // reference key cache
  int      ckl = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (dp_mode)
      1:       dp_ready = ~dp_ready;
      2:       dp_ready = 1'($urandom_range(0, 1));
      default: dp_ready = 1'b1;
    endcase
  end

  // Key expander stand-in: ready drops on init, rises key_lat cycles later (0 = never).
  int rem = 0;
  bit armed = 0;
  initial forever begin
    @(negedge clk);
    if (key_init) begin
      key_ready = 1'b0;
      rem   = key_lat - 1;
      armed = (key_lat > 0);
    end else if (armed) begin
      if (rem == 0) begin
        key_ready = 1'b1;
        armed = 0;
      end else begin
        rem--;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (round_en) strobes.push_back('{int'(round_idx), round_first, round_last});
      if (key_init) begin n_init++; init_cyc = cyc; end
      if (done)     begin n_done++; done_cyc = cyc; end
      if (key_err)  begin n_err++;  err_cyc  = cyc; end
    end
  end

  task automatic run_op(input int kl, input bit d, input int dpm, input int klat,
                        input bit kc_start, input int kc_at, input int abort_at,
                        input string tag);
    int nr, k, exp_strobes, nchk;
    bit hit, exp_init, exp_err, exp_done, fin;
    nr          = (kl == 0) ? 10 : (kl == 1) ? 12 : 14;
    hit         = cv && (ckl == kl) && !kc_start;
    exp_init    = (kl != 3) && !hit;
    exp_err     = (kl == 3) || (exp_init && klat == 0);
    exp_done    = !exp_err && (abort_at == 0);
    exp_strobes = exp_err ? 0 : (abort_at != 0) ? abort_at - 1 : nr + 1;
    strobes.delete();
    n_init = 0; n_done = 0; n_err = 0;
    dp_mode = dpm;
    key_lat = klat;

    @(posedge clk);
    #1;
    start = 1'b1; dec = d; keylen = 2'(kl); key_change = kc_start;
    k = cyc;
    fin = 0;
    for (int n = 0; n < 400 && !fin; n++) begin
      @(posedge clk);
      #1;
      start      = 1'b0;
      key_change = (kc_at != 0) && (cyc == k + kc_at);
      abort      = (abort_at != 0) && (cyc == k + abort_at);
      @(negedge clk);
      if (abort) begin
        check({tag, ".abort_round_en"}, round_en, 0);
        check({tag, ".abort_idx"}, round_idx, abort_at - 1);
      end
      if (n_err > 0 && kl == 3) check({tag, ".rsvd_busy"}, busy, 0);
      if (n_done > 0 || n_err > 0 || (abort_at != 0 && cyc > k + abort_at && !busy)) fin = 1;
    end
    if (!fin) check({tag, ".terminated"}, 0, 1);
    repeat (2) begin
      @(posedge clk);
      #1;
      abort = 1'b0;
      key_change = 1'b0;
      @(negedge clk);
    end

    check({tag, ".key_init"}, n_init, exp_init);
    check({tag, ".done"}, n_done, exp_done);
    check({tag, ".key_err"}, n_err, exp_err);
    check({tag, ".strobes"}, strobes.size(), exp_strobes);
    check({tag, ".idle"}, busy, 0);
    nchk = (strobes.size() < exp_strobes) ? strobes.size() : exp_strobes;
    for (int i = 0; i < nchk; i++) begin
      check($sformatf("%s.idx%0d", tag, i), strobes[i].idx, d ? nr - i : i);
      check($sformatf("%s.first%0d", tag, i), strobes[i].first, i == 0);
      check($sformatf("%s.last%0d", tag, i), strobes[i].last, i == nr);
    end
    if (exp_done && dpm == 0 && n_done > 0)
      check({tag, ".latency"}, done_cyc - k, nr + 2 + (exp_init ? klat + 1 : 0));
    if (kl == 3 && n_err > 0) check({tag, ".rsvd_lat"}, err_cyc - k, 1);
    if (kl != 3 && exp_err && n_err > 0 && n_init > 0)
      check({tag, ".tmo_lat"}, err_cyc - init_cyc, KWM + 1);

    if (kc_start) cv = 0;
    if (exp_init) begin
      if (klat == 0) cv = 0;
      else begin cv = 1; ckl = kl; end
    end
    if (kc_at != 0) cv = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int kl, r;
    repeat (3) @(negedge clk);
    check("reset.outputs",
          {key_init, round_en, round_idx, round_first, round_last, busy, done, key_err}, 0);
    rst_n = 1'b1;

    run_op(2, 0, 0, 5, 0, 0, 0, "enc256");
    run_op(2, 1, 0, 5, 0, 0, 0, "dec256_cached");
    run_op(0, 0, 1, 3, 0, 0, 0, "enc128_toggle");
    run_op(3, 0, 0, 3, 0, 0, 0, "rsvd");
    run_op(1, 0, 0, 0, 0, 0, 0, "timeout");
    run_op(1, 0, 0, 4, 0, 0, 0, "after_tmo");
    run_op(1, 0, 0, 4, 0, 0, 6, "abort");
    run_op(1, 0, 0, 4, 0, 0, 0, "after_abort");
    run_op(1, 1, 0, 4, 0, 3, 0, "kc_mid");
    run_op(1, 0, 0, 4, 0, 0, 0, "after_kc");
    run_op(1, 0, 0, 4, 1, 0, 0, "kc_with_start");

    // Asynchronous reset in the middle of a cached operation.
    dp_mode = 0;
    @(posedge clk);
    #1;
    start = 1'b1; keylen = 2'd1; dec = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_mid.active", {busy, round_en}, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid.outputs",
          {key_init, round_en, round_idx, round_first, round_last, busy, done, key_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cv = 0;
    run_op(1, 0, 0, 4, 0, 0, 0, "after_reset");

    for (int t = 0; t < 40; t++) begin
      r  = $urandom_range(0, 9);
      kl = (r == 9) ? 3 : r % 3;
      if ($urandom_range(0, 5) == 0) begin
        @(posedge clk);
        #1;
        key_change = 1'b1;
        @(posedge clk);
        #1;
        key_change = 1'b0;
        cv = 0;
      end
      run_op(kl, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(1, 6),
             $urandom_range(0, 7) == 0, 0, 0, $sformatf("rnd%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
